keccak_lane_loader: RTL and testbench

KECCAK_LANE_LOADER -- requirements
Module: keccak_lane_loader

---
 rtl/keccak_lane_loader.sv | 124 ++++++++++++
 tb/tb_keccak_lane_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/keccak_lane_loader.sv
// Serial-to-parallel loader: collects 25 lanes (lane 0 first) into a Keccak state
// and presents it to the Theta stage with a valid/ready handoff.
module keccak_lane_loader #(
   parameter int unsigned LANE_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [LANE_W-1:0] in_lane,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANE_W-1:0] out_data_0,
   output logic [LANE_W-1:0] out_data_1,
   output logic [LANE_W-1:0] out_data_2,
   output logic [LANE_W-1:0] out_data_3,
   output logic [LANE_W-1:0] out_data_4,
   output logic [LANE_W-1:0] out_data_5,
   output logic [LANE_W-1:0] out_data_6,
   output logic [LANE_W-1:0] out_data_7,
   output logic [LANE_W-1:0] out_data_8,
   output logic [LANE_W-1:0] out_data_9,
   output logic [LANE_W-1:0] out_data_10,
   output logic [LANE_W-1:0] out_data_11,
   output logic [LANE_W-1:0] out_data_12,
   output logic [LANE_W-1:0] out_data_13,
   output logic [LANE_W-1:0] out_data_14,
   output logic [LANE_W-1:0] out_data_15,
   output logic [LANE_W-1:0] out_data_16,
   output logic [LANE_W-1:0] out_data_17,
   output logic [LANE_W-1:0] out_data_18,
   output logic [LANE_W-1:0] out_data_19,
   output logic [LANE_W-1:0] out_data_20,
   output logic [LANE_W-1:0] out_data_21,
   output logic [LANE_W-1:0] out_data_22,
   output logic [LANE_W-1:0] out_data_23,
   output logic [LANE_W-1:0] out_data_24,
   output logic [4:0]        lane_cnt
);

   typedef enum logic {FILL, FULL} state_e;

   state_e            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [LANE_W-1:0] lanes_q [25];
   logic [LANE_W-1:0] lanes_d [25];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         for (int unsigned i = 0; i < 25; i++) lanes_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int unsigned i = 0; i < 25; i++) lanes_q[i] <= lanes_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      for (int unsigned i = 0; i < 25; i++) lanes_d[i] = lanes_q[i];
      if (flush) begin
         state_d = FILL;
         cnt_d   = '0;
         for (int unsigned i = 0; i < 25; i++) lanes_d[i] = '0;
      end else begin
         case (state_q)
            FILL: begin
               if (in_valid) begin
                  // Decoded write keeps every store inside lanes 0..24.
                  for (int unsigned i = 0; i < 25; i++)
                     if (cnt_q == 5'(i)) lanes_d[i] = in_lane;
                  if (cnt_q == 5'd24) begin
                     cnt_d   = '0;
                     state_d = FULL;
                  end else begin
                     cnt_d = cnt_q + 5'd1;
                  end
               end
            end
            FULL: begin
               if (out_ready) state_d = FILL;
            end
            default: state_d = FILL;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q == FILL) && !rst;
      out_valid = (state_q == FULL);
      lane_cnt  = cnt_q;
   end

   assign out_data_0  = lanes_q[0];
   assign out_data_1  = lanes_q[1];
   assign out_data_2  = lanes_q[2];
   assign out_data_3  = lanes_q[3];
   assign out_data_4  = lanes_q[4];
   assign out_data_5  = lanes_q[5];
   assign out_data_6  = lanes_q[6];
   assign out_data_7  = lanes_q[7];
   assign out_data_8  = lanes_q[8];
   assign out_data_9  = lanes_q[9];
   assign out_data_10 = lanes_q[10];
   assign out_data_11 = lanes_q[11];
   assign out_data_12 = lanes_q[12];
   assign out_data_13 = lanes_q[13];
   assign out_data_14 = lanes_q[14];
   assign out_data_15 = lanes_q[15];
   assign out_data_16 = lanes_q[16];
   assign out_data_17 = lanes_q[17];
   assign out_data_18 = lanes_q[18];
   assign out_data_19 = lanes_q[19];
   assign out_data_20 = lanes_q[20];
   assign out_data_21 = lanes_q[21];
   assign out_data_22 = lanes_q[22];
   assign out_data_23 = lanes_q[23];
   assign out_data_24 = lanes_q[24];

endmodule

// File: tb/tb_keccak_lane_loader.sv
// Directed/random bench for keccak_lane_loader against a queue-based lane model,
// including a Theta reference applied to the loaded state.
module tb_keccak_lane_loader;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [63:0] in_lane;
   logic        in_ready, out_valid;
   logic [4:0]  lane_cnt;
   logic [63:0] dout [25];

   int n_checks = 0;
   int n_err    = 0;
   int cycle    = 0;

   // Reference model: lanes of the current state, pending lanes, full flag.
   logic [63:0] m_regs [25];
   logic [63:0] m_pend [$];
   bit          m_full;
   int          last_accept;
   int          accept_gap;

   always #5 clk = ~clk;

   keccak_lane_loader #(.LANE_W(64)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_lane(in_lane),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data_0(dout[0]),   .out_data_1(dout[1]),   .out_data_2(dout[2]),
      .out_data_3(dout[3]),   .out_data_4(dout[4]),   .out_data_5(dout[5]),
      .out_data_6(dout[6]),   .out_data_7(dout[7]),   .out_data_8(dout[8]),
      .out_data_9(dout[9]),   .out_data_10(dout[10]), .out_data_11(dout[11]),
      .out_data_12(dout[12]), .out_data_13(dout[13]), .out_data_14(dout[14]),
      .out_data_15(dout[15]), .out_data_16(dout[16]), .out_data_17(dout[17]),
      .out_data_18(dout[18]), .out_data_19(dout[19]), .out_data_20(dout[20]),
      .out_data_21(dout[21]), .out_data_22(dout[22]), .out_data_23(dout[23]),
      .out_data_24(dout[24]),
      .lane_cnt(lane_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 25; i++) m_regs[i] = '0;
      m_pend.delete();
      m_full = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".in_ready"},  64'(in_ready),  64'(!m_full && !rst));
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_full));
      chk({tag, ".lane_cnt"},  64'(lane_cnt),  64'(m_pend.size()));
      for (int i = 0; i < 25; i++)
         chk($sformatf("%s.lane%0d", tag, i), dout[i], m_regs[i]);
   endtask

   // One clock edge; the model consumes the inputs that were present at the edge.
   task automatic tick();
      bit          fl, iv, ordy;
      logic [63:0] il;
      fl = flush; iv = in_valid; ordy = out_ready; il = in_lane;
      @(posedge clk);
      #1;
      cycle++;
      if (fl) begin
         model_clear();
      end else if (!m_full) begin
         if (iv) begin
            accept_gap  = cycle - last_accept;
            last_accept = cycle;
            m_regs[m_pend.size()] = il;
            m_pend.push_back(il);
            if (m_pend.size() == 25) begin
               m_full = 1'b1;
               m_pend.delete();
            end
         end
      end else if (ordy) begin
         m_full = 1'b0;
      end
   endtask

   task automatic send(input logic [63:0] v);
      in_valid = 1'b1; in_lane = v;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   function automatic logic [63:0] rol1(input logic [63:0] v);
      return {v[62:0], v[63]};
   endfunction

   task automatic theta_check(input string tag);
      logic [63:0] cd [5], cm [5];
      logic [63:0] dd, dm;
      for (int x = 0; x < 5; x++) begin
         cd[x] = '0; cm[x] = '0;
         for (int y = 0; y < 5; y++) begin
            cd[x] ^= dout[x + 5*y];
            cm[x] ^= m_regs[x + 5*y];
         end
      end
      for (int x = 0; x < 5; x++) begin
         dd = cd[(x + 4) % 5] ^ rol1(cd[(x + 1) % 5]);
         dm = cm[(x + 4) % 5] ^ rol1(cm[(x + 1) % 5]);
         for (int y = 0; y < 5; y++)
            chk($sformatf("%s.theta%0d", tag, x + 5*y),
                dout[x + 5*y] ^ dd, m_regs[x + 5*y] ^ dm);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_lane = '0;
      model_clear();
      last_accept = 0; accept_gap = 0;
      #3;
      check_all("reset_held");
      #9 rst = 1'b0;
      #1;
      check_all("reset_release");

      // Sequential load with values i+1.
      for (int i = 0; i < 25; i++) begin
         send(64'(i + 1));
         if (i == 11) check_all("mid_fill");
      end
      check_all("full_after_25");

      // Hold full: in_valid ignored, outputs stable.
      in_valid = 1'b1; in_lane = '1;
      for (int k = 0; k < 10; k++) tick();
      check_all("full_hold");
      in_valid = 1'b0;
      handoff();
      check_all("handoff");

      // Random gaps, then flush coinciding with the 13th lane.
      for (int i = 0; i < 12; i++) begin
         int unsigned gap = $urandom_range(0, 3);
         for (int unsigned g = 0; g < gap; g++) tick();
         send({$urandom, $urandom});
      end
      check_all("partial12");
      flush = 1'b1;
      send({$urandom, $urandom});
      flush = 1'b0;
      check_all("flush_drop");
      for (int i = 0; i < 25; i++) send({$urandom, $urandom});
      check_all("fresh_after_flush");
      flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0; out_ready = 1'b0;
      check_all("flush_over_handoff");

      // Asynchronous reset mid-fill.
      for (int i = 0; i < 7; i++) send({$urandom, $urandom});
      #2 rst = 1'b1;
      #1;
      model_clear();
      check_all("async_reset");
      #1 rst = 1'b0;
      tick();
      check_all("after_async_reset");
      for (int i = 0; i < 25; i++) send({$urandom, $urandom});
      check_all("load_after_reset");
      handoff();

      // Three back-to-back states with handoff one cycle after out_valid.
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 25; i++) begin
            send({$urandom, $urandom});
            if (s > 0 && i == 0) chk($sformatf("b2b_gap%0d", s), 64'(accept_gap), 64'd2);
         end
         check_all($sformatf("b2b_state%0d", s));
         handoff();
      end

      // Theta on all-zero and random states.
      for (int i = 0; i < 25; i++) send('0);
      check_all("zero_state");
      theta_check("theta_zero");
      handoff();
      for (int i = 0; i < 25; i++) send({$urandom, $urandom});
      theta_check("theta_rand");
      check_all("rand_state");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
